// File: rtl/md_unit.sv
// RV32/64 M-extension multiply/divide unit: iterative radix-2 shift-add multiply
// and restoring divide on operand magnitudes, with a final sign-fix cycle.
module md_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [2:0]      FUNC3,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  input  logic [4:0]      REG_WRITE_ADDR_IN,
  input  logic            FLUSH,
  input  logic            HOLD,
  output logic            BUSY,
  output logic            RESULT_VALID,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      REG_WRITE_ADDR_OUT
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t              state, state_next;
  logic [CNT_W-1:0]    cnt;
  logic [2:0]          func_q;
  logic                a_neg, b_neg;
  logic                special_q;
  logic [XLEN-1:0]     operand;
  logic [2*XLEN-1:0]   acc;

  logic                accept;
  logic                a_signed, b_signed;
  logic                a_neg_in, b_neg_in;
  logic [XLEN-1:0]     a_mag_in, b_mag_in;
  logic                div_zero, div_ovf, special_in;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_trial;
  logic [2*XLEN-1:0]   step_next;
  logic [2*XLEN-1:0]   prod_s;
  logic [XLEN-1:0]     fix_res;
  logic                last_step;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (FUNC3)
      3'b000, 3'b001, 3'b100, 3'b110: begin
        a_signed = 1'b1;
        b_signed = 1'b1;
      end
      3'b010:  a_signed = 1'b1;
      default: ;
    endcase
  end

  assign a_neg_in = a_signed & OP_A[XLEN-1];
  assign b_neg_in = b_signed & OP_B[XLEN-1];
  assign a_mag_in = a_neg_in ? -OP_A : OP_A;
  assign b_mag_in = b_neg_in ? -OP_B : OP_B;

  assign div_zero   = FUNC3[2] && (OP_B == '0);
  assign div_ovf    = FUNC3[2] && !FUNC3[0] &&
                      (OP_A == {1'b1, {(XLEN-1){1'b0}}}) && (OP_B == '1);
  assign special_in = div_zero | div_ovf;

  // FUNC3[1] selects the remainder flavour of the special-case answer
  always_comb begin
    if (div_zero) special_res = FUNC3[1] ? OP_A : '1;
    else          special_res = FUNC3[1] ? '0 : OP_A;
  end

  assign accept = START && !FLUSH &&
                  ((state == IDLE) || ((state == DONE) && !HOLD));

  assign last_step = (cnt == CNT_W'(XLEN - 1));

  // One iteration: multiply adds the multiplicand into the upper half and shifts
  // right; divide shifts {rem,quo} left and keeps the trial subtraction if it fits.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    div_trial = acc[2*XLEN-1:XLEN-1] - {1'b0, operand};
    if (!func_q[2])
      step_next = {mul_sum, acc[XLEN-1:1]};
    else if (!div_trial[XLEN])
      step_next = {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    else
      step_next = {acc[2*XLEN-2:0], 1'b0};
  end

  assign prod_s = (a_neg ^ b_neg) ? -acc : acc;

  always_comb begin
    case (func_q)
      3'b000:                 fix_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_res = (a_neg ^ b_neg) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      default:                fix_res = a_neg ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next   = state;
    BUSY         = 1'b0;
    RESULT_VALID = 1'b0;
    case (state)
      IDLE: if (accept) state_next = CALC;
      CALC: begin
        BUSY = 1'b1;
        if (special_q)      state_next = DONE;
        else if (last_step) state_next = FIX;
      end
      FIX: begin
        BUSY       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        RESULT_VALID = 1'b1;
        if (!HOLD) state_next = accept ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (FLUSH) state_next = IDLE;
  end

  // Special-case answers ride in acc so RESULT only changes on entry to DONE
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt                <= '0;
      func_q             <= '0;
      a_neg              <= 1'b0;
      b_neg              <= 1'b0;
      special_q          <= 1'b0;
      operand            <= '0;
      acc                <= '0;
      RESULT             <= '0;
      REG_WRITE_ADDR_OUT <= '0;
    end else if (accept) begin
      cnt                <= '0;
      func_q             <= FUNC3;
      a_neg              <= a_neg_in;
      b_neg              <= b_neg_in;
      special_q          <= special_in;
      REG_WRITE_ADDR_OUT <= REG_WRITE_ADDR_IN;
      if (special_in) begin
        operand <= '0;
        acc     <= {{XLEN{1'b0}}, special_res};
      end else if (FUNC3[2]) begin
        operand <= b_mag_in;
        acc     <= {{XLEN{1'b0}}, a_mag_in};
      end else begin
        operand <= a_mag_in;
        acc     <= {{XLEN{1'b0}}, b_mag_in};
      end
    end else if (!FLUSH && (state == CALC)) begin
      if (special_q) begin
        RESULT <= acc[XLEN-1:0];
      end else begin
        cnt <= cnt + CNT_W'(1);
        acc <= step_next;
      end
    end else if (!FLUSH && (state == FIX)) begin
      RESULT <= fix_res;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_md_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  logic            CLK = 1'b0;
  logic            RESET;
  logic            START;
  logic [2:0]      FUNC3;
  logic [XLEN-1:0] OP_A, OP_B;
  logic [4:0]      REG_WRITE_ADDR_IN;
  logic            FLUSH;
  logic            HOLD;
  logic            BUSY;
  logic            RESULT_VALID;
  logic [XLEN-1:0] RESULT;
  logic [4:0]      REG_WRITE_ADDR_OUT;

  int check_cnt = 0;
  int pass_cnt  = 0;

  md_unit #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .FUNC3(FUNC3),
    .OP_A(OP_A), .OP_B(OP_B), .REG_WRITE_ADDR_IN(REG_WRITE_ADDR_IN),
    .FLUSH(FLUSH), .HOLD(HOLD), .BUSY(BUSY), .RESULT_VALID(RESULT_VALID),
    .RESULT(RESULT), .REG_WRITE_ADDR_OUT(REG_WRITE_ADDR_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    check_cnt++;
    if (obs === exp) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF));
  endfunction

  // Reference: widen to 64 bits and let the simulator's arithmetic do the work
  function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == MIN_INT) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: if (b == 0) return 32'hFFFF_FFFF; else if (ovf) return a; else return 32'(sa / sb);
      3'd5: if (b == 0) return 32'hFFFF_FFFF; else return a / b;
      3'd6: if (b == 0) return a; else if (ovf) return 32'd0; else return 32'(sa % sb);
      default: if (b == 0) return a; else return a % b;
    endcase
  endfunction

  // Presents one op with START and returns just after the accept edge,
  // scrambling the inputs so latching is exercised
  task automatic applyStimulus(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    FUNC3 = f; OP_A = a; OP_B = b; REG_WRITE_ADDR_IN = t; START = 1'b1;
    tick();
    START = 1'b0;
    FUNC3 = 3'($urandom); OP_A = $urandom; OP_B = $urandom; REG_WRITE_ADDR_IN = 5'($urandom);
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp, input logic [4:0] t, input int exp_lat);
    int n;
    n = 1;
    tick();
    while (!RESULT_VALID && n < 200) begin
      tick();
      n++;
    end
    checkOutput({name, "_latency"}, 64'(n), 64'(exp_lat));
    checkOutput({name, "_result"}, 64'(RESULT), 64'(exp));
    checkOutput({name, "_tag"}, 64'(REG_WRITE_ADDR_OUT), 64'(t));
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
    int lat;
    lat = is_special(f, a, b) ? 1 : XLEN + 1;
    applyStimulus(f, a, b, t);
    checkOutput({name, "_busy"}, 64'(BUSY), 64'd1);
    wait_result(name, ref_result(f, a, b), t, lat);
  endtask

  task automatic leave_done(input string name);
    tick();
    checkOutput({name, "_idle"}, 64'(RESULT_VALID), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return MIN_INT;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    RESET = 1'b0; START = 1'b0; FLUSH = 1'b0; HOLD = 1'b0;
    FUNC3 = '0; OP_A = '0; OP_B = '0; REG_WRITE_ADDR_IN = '0;
    #22;
    checkOutput("rst_busy", 64'(BUSY), 64'd0);
    checkOutput("rst_valid", 64'(RESULT_VALID), 64'd0);
    checkOutput("rst_result", 64'(RESULT), 64'd0);
    checkOutput("rst_tag", 64'(REG_WRITE_ADDR_OUT), 64'd0);
    RESET = 1'b1;

    // First edge after reset release accepts the op
    run_op("mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5);
    checkOutput("mul_spec", 64'(RESULT), 64'hFFFF_FFEB);
    leave_done("mul");
    run_op("mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    checkOutput("mulhu_spec", 64'(RESULT), 64'hFFFF_FFFE);
    leave_done("mulhu");
    run_op("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 5'd7);
    checkOutput("div_spec", 64'(RESULT), 64'hFFFF_FFFD);
    leave_done("div");
    run_op("rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 5'd8);
    checkOutput("rem_spec", 64'(RESULT), 64'hFFFF_FFFF);
    leave_done("rem");
    run_op("divu0", 3'd5, 32'd5, 32'd0, 5'd9);
    leave_done("divu0");
    run_op("remu0", 3'd7, 32'd5, 32'd0, 5'd10);
    checkOutput("remu0_spec", 64'(RESULT), 64'd5);
    leave_done("remu0");
    run_op("divovf", 3'd4, MIN_INT, 32'hFFFF_FFFF, 5'd11);
    checkOutput("divovf_spec", 64'(RESULT), 64'h8000_0000);
    leave_done("divovf");
    run_op("removf", 3'd6, MIN_INT, 32'hFFFF_FFFF, 5'd12);
    leave_done("removf");

    // START during CALC must not disturb the running op
    applyStimulus(3'd5, 32'd100, 32'd7, 5'd3);
    FUNC3 = 3'd0; OP_A = 32'd9; OP_B = 32'd9; START = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    START = 1'b0;
    wait_result("ignore_start", 32'd14, 5'd3, XLEN + 1 - 5);
    leave_done("ignore_start");

    // FLUSH at counter=10
    applyStimulus(3'd0, 32'd123, 32'd456, 5'd4);
    for (int i = 0; i < 10; i++) tick();
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checkOutput("flush_busy", 64'(BUSY), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      seen += int'(RESULT_VALID);
      tick();
    end
    checkOutput("flush_novalid", 64'(seen), 64'd0);

    // START and FLUSH together are not accepted
    FUNC3 = 3'd0; START = 1'b1; FLUSH = 1'b1;
    tick();
    START = 1'b0; FLUSH = 1'b0;
    checkOutput("collide_busy", 64'(BUSY), 64'd0);

    // HOLD in DONE, then back-to-back accept on release
    run_op("hold", 3'd1, 32'hDEAD_BEEF, 32'h1234_5678, 5'd9);
    HOLD = 1'b1; FUNC3 = 3'd5; OP_A = 32'd50; OP_B = 32'd6; REG_WRITE_ADDR_IN = 5'd12; START = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("hold_valid", 64'(RESULT_VALID), 64'd1);
      checkOutput("hold_result", 64'(RESULT), 64'(ref_result(3'd1, 32'hDEAD_BEEF, 32'h1234_5678)));
      checkOutput("hold_tag", 64'(REG_WRITE_ADDR_OUT), 64'd9);
      checkOutput("hold_busy", 64'(BUSY), 64'd0);
    end
    HOLD = 1'b0;
    tick();
    START = 1'b0;
    checkOutput("b2b_busy", 64'(BUSY), 64'd1);
    checkOutput("b2b_valid", 64'(RESULT_VALID), 64'd0);
    wait_result("b2b", 32'd8, 5'd12, XLEN + 1);

    // FLUSH beats HOLD in DONE
    FLUSH = 1'b1; HOLD = 1'b1;
    tick();
    FLUSH = 1'b0; HOLD = 1'b0;
    checkOutput("flush_done_valid", 64'(RESULT_VALID), 64'd0);

    // Asynchronous reset mid-CALC
    applyStimulus(3'd0, 32'd3, 32'd3, 5'd17);
    for (int i = 0; i < 5; i++) tick();
    #2 RESET = 1'b0;
    #1;
    checkOutput("arst_busy", 64'(BUSY), 64'd0);
    checkOutput("arst_valid", 64'(RESULT_VALID), 64'd0);
    checkOutput("arst_result", 64'(RESULT), 64'd0);
    checkOutput("arst_tag", 64'(REG_WRITE_ADDR_OUT), 64'd0);
    #2 RESET = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      seen += int'(RESULT_VALID);
    end
    checkOutput("arst_novalid", 64'(seen), 64'd0);

    // Randomized ops against the model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          hold_cycles;
      f = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, 5'($urandom));
      hold_cycles = $urandom_range(0, 2);
      HOLD = 1'b1;
      for (int h = 0; h < hold_cycles; h++) tick();
      HOLD = 1'b0;
      checkOutput("rand_hold_result", 64'(RESULT), 64'(ref_result(f, a, b)));
      leave_done("rand");
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
